instruction_decode_stage: RTL and testbench

- Decode stage directly upstream of the decode-output pipeline register.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and produces the registered control bundle that the pipeline register latches: AR, BR, ALU[3:0], input, wren, writeAd[2:0], ADR_MUX, write, PC_load.
- Contains a small control FSM for two-cycle loads, plus an 8-entry register scoreboard that stalls on RAW hazards until writeback reports completion.

---
 rtl/instruction_decode_stage_pkg.sv | 109 ++++++++++
 rtl/instruction_decode_stage_scoreboard.sv | 69 ++++++
 rtl/instruction_decode_stage.sv | 162 ++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_decode_stage_pkg                                    |
// | Purpose  : Shared definitions for the decode stage. Holds the opcode map,  |
// |            the instruction field positions, the FSM state encoding, the    |
// |            registered control bundle, and decode helper functions.        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package instruction_decode_stage_pkg;

   // Instruction field positions for a 16-bit instruction word.
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RD_MSB = 11;
   localparam int RD_LSB = 9;
   localparam int RS_MSB = 8;
   localparam int RS_LSB = 6;
   localparam int RT_MSB = 5;
   localparam int RT_LSB = 3;

   // Opcode map. Opcodes 0x1 through 0x7 are ALU operations.
   // Opcodes 0xD through 0xF are undefined.
   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_ALU_LO = 4'h1;
   localparam logic [3:0] OP_ALU_HI = 4'h7;
   localparam logic [3:0] OP_LD     = 4'h8;
   localparam logic [3:0] OP_ST     = 4'h9;
   localparam logic [3:0] OP_IN     = 4'hA;
   localparam logic [3:0] OP_JMP    = 4'hB;
   localparam logic [3:0] OP_BZ     = 4'hC;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_LOAD2  = 2'd1,
      S_HAZARD = 2'd2
   } state_e;

   // Control bundle handed to the decode-output pipeline register.
   typedef struct packed {
      logic       illegal;
      logic       ar;
      logic       br;
      logic [3:0] alu;
      logic       inp;
      logic       wren;
      logic [2:0] wr_ad;
      logic       adr_mux;
      logic       write;
      logic       pc_load;
   } ctrl_t;

   function automatic logic is_alu(input logic [3:0] op);
      return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
   endfunction

   function automatic logic reads_rs(input logic [3:0] op);
      return is_alu(op) || (op == OP_ST) || (op == OP_LD);
   endfunction

   function automatic logic reads_rt(input logic [3:0] op);
      return is_alu(op) || (op == OP_ST);
   endfunction

   function automatic logic writes_rd(input logic [3:0] op);
      return is_alu(op) || (op == OP_IN) || (op == OP_LD);
   endfunction

   // Single-cycle decode. For LD this produces only the address cycle; the
   // register-write cycle is emitted by the LOAD2 state.
   function automatic ctrl_t decode_op(input logic [3:0] op,
                                       input logic [2:0] rd,
                                       input logic       zero);
      ctrl_t c;
      c = '0;
      if (is_alu(op)) begin
         c.alu   = op;
         c.ar    = 1'b1;
         c.br    = 1'b1;
         c.write = 1'b1;
         c.wr_ad = rd;
      end else begin
         case (op)
            OP_NOP: ;
            OP_LD: begin
               c.ar      = 1'b1;
               c.adr_mux = 1'b1;
            end
            OP_ST: begin
               c.ar      = 1'b1;
               c.br      = 1'b1;
               c.adr_mux = 1'b1;
               c.wren    = 1'b1;
            end
            OP_IN: begin
               c.inp   = 1'b1;
               c.write = 1'b1;
               c.wr_ad = rd;
            end
            OP_JMP:  c.pc_load = 1'b1;
            OP_BZ:   c.pc_load = zero;
            default: c.illegal = 1'b1;
         endcase
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decode_stage_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_scoreboard                                               |
// | Purpose  : Pending-write bit per architectural register. A bit is set when |
// |            a register-writing instruction issues and cleared on writeback  |
// |            or when an abandoned load is flushed.                           |
// | Ports    : clk_i, rst_ni        clock / async active-low reset             |
// |            set_i, set_addr_i    mark register pending (set wins)           |
// |            clr_i, clr_addr_i    writeback retire                           |
// |            fl_clr_i, fl_addr_i  flush-clear of an abandoned load           |
// |            rs/rt/rd_addr_i      lookup addresses                           |
// |            busy_*_o             pending bit now                            |
// |            busy_*_nxt_o         pending bit once this cycle's clears land  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module decode_scoreboard #(
   parameter int NREG = 8,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          set_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic          fl_clr_i,
   input  logic [AW-1:0] fl_addr_i,
   input  logic [AW-1:0] rs_addr_i,
   input  logic [AW-1:0] rt_addr_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic          busy_rs_o,
   output logic          busy_rt_o,
   output logic          busy_rd_o,
   output logic          busy_rs_nxt_o,
   output logic          busy_rt_nxt_o,
   output logic          busy_rd_nxt_o
);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] kept;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_i)    set_mask[set_addr_i] = 1'b1;
      if (clr_i)    clr_mask[clr_addr_i] = 1'b1;
      if (fl_clr_i) clr_mask[fl_addr_i]  = 1'b1;
      kept   = pend_q & ~clr_mask;
      // Set is OR-ed in last so it dominates a same-cycle clear.
      pend_d = kept | set_mask;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pend_q <= '0;
      else         pend_q <= pend_d;
   end

   assign busy_rs_o     = pend_q[rs_addr_i];
   assign busy_rt_o     = pend_q[rt_addr_i];
   assign busy_rd_o     = pend_q[rd_addr_i];
   assign busy_rs_nxt_o = kept[rs_addr_i];
   assign busy_rt_nxt_o = kept[rt_addr_i];
   assign busy_rd_nxt_o = kept[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/instruction_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_decode_stage                                        |
// | Purpose  : Decodes 16-bit instructions from fetch into the registered      |
// |            control bundle latched by the decode-output pipeline register.  |
// |            Two-cycle loads are sequenced by a small FSM, and RAW/WAW       |
// |            hazards stall on a register scoreboard.                         |
// | Ports    : CLK, RSTN                 clock / async active-low reset        |
// |            INSTR_IN/VALID/READY      fetch handshake                       |
// |            ZERO_IN                   ALU zero flag for BZ                  |
// |            WB_VALID, WB_ADDR         writeback retire                      |
// |            FLUSH                     kill in-flight decode                 |
// |            *_OUT, ILLEGAL            registered controls                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module instruction_decode_stage
   import instruction_decode_stage_pkg::*;
#(
   parameter int IW   = 16,
   parameter int NREG = 8
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic [IW-1:0] INSTR_IN,
   input  logic          INSTR_VALID,
   output logic          INSTR_READY,
   input  logic          ZERO_IN,
   input  logic          WB_VALID,
   input  logic [2:0]    WB_ADDR,
   input  logic          FLUSH,
   output logic          AR_OUT,
   output logic          BR_OUT,
   output logic [3:0]    ALU_OUT,
   output logic          input_OUT,
   output logic          wren_OUT,
   output logic [2:0]    writeAd_OUT,
   output logic          ADR_MUX_OUT,
   output logic          write_OUT,
   output logic          PC_load_OUT,
   output logic          ILLEGAL
);

   state_e     state_q, state_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic [2:0] ld_rd_q, ld_rd_d;
   logic       rdy_q;

   logic [3:0] op;
   logic [2:0] rd, rs, rt;
   logic       busy_rs, busy_rt, busy_rd;
   logic       busy_rs_nxt, busy_rt_nxt, busy_rd_nxt;
   logic       hazard, hazard_nxt;
   logic       accept;
   logic       sb_set;
   logic       sb_fl_clr;
   logic       unused_bits;

   assign op = INSTR_IN[OP_MSB:OP_LSB];
   assign rd = INSTR_IN[RD_MSB:RD_LSB];
   assign rs = INSTR_IN[RS_MSB:RS_LSB];
   assign rt = INSTR_IN[RT_MSB:RT_LSB];
   assign unused_bits = ^INSTR_IN[2:0];

   // Hazard against the current pending vector (used in RUN), and against
   // the vector after this cycle's writeback clear, so HAZARD can leave on
   // the same edge the blocking bit retires.
   assign hazard = INSTR_VALID &
                   ((reads_rs(op)  & busy_rs) |
                    (reads_rt(op)  & busy_rt) |
                    (writes_rd(op) & busy_rd));
   assign hazard_nxt = INSTR_VALID &
                       ((reads_rs(op)  & busy_rs_nxt) |
                        (reads_rt(op)  & busy_rt_nxt) |
                        (writes_rd(op) & busy_rd_nxt));

   assign INSTR_READY = rdy_q & (state_q == S_RUN) & ~hazard & ~FLUSH;
   assign accept      = INSTR_VALID & INSTR_READY;
   assign sb_set      = accept & writes_rd(op);
   // A flushed load never writes back, so its pending bit must be dropped.
   assign sb_fl_clr   = FLUSH & (state_q == S_LOAD2);

   decode_scoreboard #(
      .NREG (NREG)
   ) u_sb (
      .clk_i         (CLK),
      .rst_ni        (RSTN),
      .set_i         (sb_set),
      .set_addr_i    (rd),
      .clr_i         (WB_VALID),
      .clr_addr_i    (WB_ADDR),
      .fl_clr_i      (sb_fl_clr),
      .fl_addr_i     (ld_rd_q),
      .rs_addr_i     (rs),
      .rt_addr_i     (rt),
      .rd_addr_i     (rd),
      .busy_rs_o     (busy_rs),
      .busy_rt_o     (busy_rt),
      .busy_rd_o     (busy_rd),
      .busy_rs_nxt_o (busy_rs_nxt),
      .busy_rt_nxt_o (busy_rt_nxt),
      .busy_rd_nxt_o (busy_rd_nxt)
   );

   always_comb begin
      state_d = state_q;
      ctrl_d  = '0;
      ld_rd_d = ld_rd_q;
      if (FLUSH) begin
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (accept) begin
                  ctrl_d = decode_op(op, rd, ZERO_IN);
                  if (op == OP_LD) begin
                     state_d = S_LOAD2;
                     ld_rd_d = rd;
                  end
               end else if (rdy_q && hazard) begin
                  state_d = S_HAZARD;
               end
            end
            S_LOAD2: begin
               ctrl_d.write = 1'b1;
               ctrl_d.wr_ad = ld_rd_q;
               state_d      = S_RUN;
            end
            S_HAZARD: begin
               if (!hazard_nxt) state_d = S_RUN;
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_RUN;
         ctrl_q  <= '0;
         ld_rd_q <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         ld_rd_q <= ld_rd_d;
         rdy_q   <= 1'b1;
      end
   end

   assign AR_OUT      = ctrl_q.ar;
   assign BR_OUT      = ctrl_q.br;
   assign ALU_OUT     = ctrl_q.alu;
   assign input_OUT   = ctrl_q.inp;
   assign wren_OUT    = ctrl_q.wren;
   assign writeAd_OUT = ctrl_q.wr_ad;
   assign ADR_MUX_OUT = ctrl_q.adr_mux;
   assign write_OUT   = ctrl_q.write;
   assign PC_load_OUT = ctrl_q.pc_load;
   assign ILLEGAL     = ctrl_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instruction_decode_stage                                     |
// | Purpose  : Self-checking bench for instruction_decode_stage. Expected      |
// |            control bundles are queued as each cycle is driven and popped   |
// |            after the following clock edge.                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instruction_decode_stage;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [15:0] INSTR_IN;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic        ZERO_IN;
   logic        WB_VALID;
   logic [2:0]  WB_ADDR;
   logic        FLUSH;
   logic        AR_OUT, BR_OUT, input_OUT, wren_OUT, ADR_MUX_OUT, write_OUT, PC_load_OUT;
   logic [3:0]  ALU_OUT;
   logic [2:0]  writeAd_OUT;
   logic        ILLEGAL;

   int n_chk = 0;
   int n_bad = 0;
   logic [14:0] exp_q[$];

   always #5 CLK = ~CLK;

   instruction_decode_stage #(.IW(16), .NREG(8)) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .INSTR_IN    (INSTR_IN),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .ZERO_IN     (ZERO_IN),
      .WB_VALID    (WB_VALID),
      .WB_ADDR     (WB_ADDR),
      .FLUSH       (FLUSH),
      .AR_OUT      (AR_OUT),
      .BR_OUT      (BR_OUT),
      .ALU_OUT     (ALU_OUT),
      .input_OUT   (input_OUT),
      .wren_OUT    (wren_OUT),
      .writeAd_OUT (writeAd_OUT),
      .ADR_MUX_OUT (ADR_MUX_OUT),
      .write_OUT   (write_OUT),
      .PC_load_OUT (PC_load_OUT),
      .ILLEGAL     (ILLEGAL)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bundle order: ILLEGAL AR BR ALU[3:0] input wren writeAd[2:0] ADR_MUX write PC_load
   function automatic logic [14:0] ex(input logic ill, input logic ar, input logic br,
                                      input logic [3:0] alu, input logic inp, input logic wren,
                                      input logic [2:0] wad, input logic adm, input logic wr,
                                      input logic pcl);
      return {ill, ar, br, alu, inp, wren, wad, adm, wr, pcl};
   endfunction

   function automatic logic [14:0] got_ctrl();
      return {ILLEGAL, AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT, writeAd_OUT,
              ADR_MUX_OUT, write_OUT, PC_load_OUT};
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   // Expected-bundle shorthands.
   function automatic logic [14:0] e_alu(input logic [3:0] op, input logic [2:0] rd);
      return ex(1'b0, 1'b1, 1'b1, op, 1'b0, 1'b0, rd, 1'b0, 1'b1, 1'b0);
   endfunction
   function automatic logic [14:0] e_ld1();
      return ex(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
   endfunction
   function automatic logic [14:0] e_ld2(input logic [2:0] rd);
      return ex(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, rd, 1'b0, 1'b1, 1'b0);
   endfunction

   // Output monitor: each clock edge retires one queued expectation.
   always @(posedge CLK) begin
      #1;
      if (exp_q.size() != 0) check("ctrl", {17'd0, got_ctrl()}, {17'd0, exp_q.pop_front()});
   end

   // Drive one cycle of inputs, check the handshake before the edge, and
   // queue the bundle expected after the edge.
   task automatic cyc(input logic [15:0] ins, input logic v, input logic z,
                      input logic wbv, input logic [2:0] wba, input logic fl,
                      input logic erdy, input logic [14:0] ectl);
      @(negedge CLK);
      INSTR_IN    = ins;
      INSTR_VALID = v;
      ZERO_IN     = z;
      WB_VALID    = wbv;
      WB_ADDR     = wba;
      FLUSH       = fl;
      #1;
      check("ready", {31'd0, INSTR_READY}, {31'd0, erdy});
      exp_q.push_back(ectl);
   endtask

   initial begin
      logic [14:0] zero_c;
      logic [15:0] i_alu2, i_haz6, i_in5;
      zero_c = '0;
      RSTN = 1'b0; INSTR_IN = '0; INSTR_VALID = 1'b0; ZERO_IN = 1'b0;
      WB_VALID = 1'b0; WB_ADDR = '0; FLUSH = 1'b0;

      repeat (2) @(posedge CLK);
      #1;
      check("rst_ctrl", {17'd0, got_ctrl()}, 32'd0);
      check("rst_ready", {31'd0, INSTR_READY}, 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      #1;
      check("rel_ready", {31'd0, INSTR_READY}, 32'd0);

      // Basic ALU issue, then RAW stall released by writeback.
      cyc(mk(4'h3, 3'd2, 3'd1, 3'd0), 1, 0, 0, 0, 0, 1, e_alu(4'h3, 3'd2));
      cyc(16'h0, 0, 0, 0, 0, 0, 1, zero_c);
      check("sb_bit2", {31'd0, dut.u_sb.pend_q[2]}, 32'd1);
      i_alu2 = mk(4'h1, 3'd3, 3'd2, 3'd0);
      cyc(i_alu2, 1, 0, 0, 0, 0, 0, zero_c);
      cyc(i_alu2, 1, 0, 0, 0, 0, 0, zero_c);
      cyc(i_alu2, 1, 0, 1, 3'd2, 0, 0, zero_c);
      cyc(i_alu2, 1, 0, 0, 0, 0, 1, e_alu(4'h1, 3'd3));
      cyc(16'h0, 0, 0, 1, 3'd3, 0, 1, zero_c);

      // Two-cycle load; NOP held by fetch during LOAD2.
      cyc(mk(4'h8, 3'd5, 3'd0, 3'd0), 1, 0, 0, 0, 0, 1, e_ld1());
      cyc(16'h0, 1, 0, 0, 0, 0, 0, e_ld2(3'd5));
      cyc(16'h0, 1, 0, 0, 0, 0, 1, zero_c);
      cyc(16'h0, 0, 0, 1, 3'd5, 0, 1, zero_c);

      // Branches, IN, ST, illegal opcode.
      cyc(mk(4'hC, 0, 0, 0), 1, 1, 0, 0, 0, 1, ex(0,0,0,4'h0,0,0,3'd0,0,0,1));
      cyc(mk(4'hC, 0, 0, 0), 1, 0, 0, 0, 0, 1, zero_c);
      cyc(mk(4'hB, 0, 0, 0), 1, 0, 0, 0, 0, 1, ex(0,0,0,4'h0,0,0,3'd0,0,0,1));
      cyc(mk(4'hA, 3'd1, 0, 0), 1, 0, 0, 0, 0, 1, ex(0,0,0,4'h0,1,0,3'd1,0,1,0));
      cyc(mk(4'h9, 3'd0, 3'd4, 3'd6), 1, 0, 1, 3'd1, 0, 1, ex(0,1,1,4'h0,0,1,3'd0,1,0,0));
      cyc(mk(4'hE, 3'd2, 3'd3, 3'd4), 1, 0, 0, 0, 0, 1, ex(1,0,0,4'h0,0,0,3'd0,0,0,0));
      cyc(16'h0, 0, 0, 0, 0, 0, 1, zero_c);

      // FLUSH during LOAD2 drops the load's pending bit.
      cyc(mk(4'h8, 3'd4, 3'd0, 3'd0), 1, 0, 0, 0, 0, 1, e_ld1());
      cyc(mk(4'h1, 3'd7, 3'd0, 3'd0), 1, 0, 0, 0, 1, 0, zero_c);
      cyc(mk(4'h8, 3'd4, 3'd0, 3'd0), 1, 0, 0, 0, 0, 1, e_ld1());
      check("flush_bit4", {31'd0, dut.u_sb.pend_q[4]}, 32'd0);
      cyc(16'h0, 0, 0, 0, 0, 0, 0, e_ld2(3'd4));
      cyc(16'h0, 0, 0, 1, 3'd4, 0, 1, zero_c);

      // Same-edge set and clear of r6: set wins, and FLUSH in HAZARD keeps it.
      cyc(mk(4'h2, 3'd6, 3'd0, 3'd0), 1, 0, 1, 3'd6, 0, 1, e_alu(4'h2, 3'd6));
      i_haz6 = mk(4'h4, 3'd0, 3'd6, 3'd0);
      cyc(i_haz6, 1, 0, 0, 0, 0, 0, zero_c);
      check("sb_bit6", {31'd0, dut.u_sb.pend_q[6]}, 32'd1);
      cyc(i_haz6, 1, 0, 0, 0, 1, 0, zero_c);
      cyc(i_haz6, 1, 0, 0, 0, 0, 0, zero_c);
      cyc(i_haz6, 1, 0, 1, 3'd6, 0, 0, zero_c);
      cyc(i_haz6, 1, 0, 0, 0, 0, 1, e_alu(4'h4, 3'd0));
      cyc(16'h0, 0, 0, 1, 3'd0, 0, 1, zero_c);

      // Asynchronous reset in the middle of LOAD2.
      cyc(mk(4'h8, 3'd5, 3'd0, 3'd0), 1, 0, 0, 0, 0, 1, e_ld1());
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      #2;
      RSTN = 1'b0;
      #1;
      check("arst_ctrl", {17'd0, got_ctrl()}, 32'd0);
      check("arst_ready", {31'd0, INSTR_READY}, 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      cyc(mk(4'h8, 3'd5, 3'd0, 3'd0), 1, 0, 0, 0, 0, 1, e_ld1());
      cyc(16'h0, 0, 0, 0, 0, 0, 0, e_ld2(3'd5));

      // WAW stall on pending r5.
      i_in5 = mk(4'hA, 3'd5, 3'd0, 3'd0);
      cyc(i_in5, 1, 0, 0, 0, 0, 0, zero_c);
      cyc(i_in5, 1, 0, 1, 3'd5, 0, 0, zero_c);
      cyc(i_in5, 1, 0, 0, 0, 0, 1, ex(0,0,0,4'h0,1,0,3'd5,0,1,0));
      cyc(16'h0, 0, 0, 1, 3'd5, 0, 1, zero_c);

      @(negedge CLK);
      @(negedge CLK);
      check("drain", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
